// File: rtl/clkdiv_pkg.sv
// Shared constants for the programmable clock-enable divider.
// Mode encodings and the ratio every channel starts from after reset.
package clkdiv_pkg;

  localparam logic        MODE_PULSE    = 1'b0;
  localparam logic        MODE_SQUARE   = 1'b1;
  localparam logic [15:0] DEFAULT_DIV_C = 16'd10;

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: wrap counter, active/pending ratio registers and
// registered TC, CLK_OUT and PEND outputs. Ratio changes land only on a wrap.
module clkdiv_channel
  import clkdiv_pkg::*;
#(
  parameter int               WIDTH       = 16,
  parameter logic [WIDTH-1:0] DEFAULT_DIV = WIDTH'(DEFAULT_DIV_C)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic [WIDTH-1:0] div,
  input  logic             div_we,
  input  logic             mode,
  output logic             tc,
  output logic             clk_out,
  output logic             pend
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] active_q, active_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic             pend_q, pend_d;
  logic             tc_q, tc_d;
  logic             clk_out_q, clk_out_d;
  logic [WIDTH-1:0] last;
  logic             wrap;

  always_comb begin
    // Ratios 0 and 1 both mean divide-by-1, i.e. the last count is 0.
    last      = (active_q == '0) ? '0 : active_q - WIDTH'(1);
    wrap      = tick && (cnt_q == last);
    cnt_d     = cnt_q;
    active_d  = active_q;
    pending_d = pending_q;
    pend_d    = pend_q;
    clk_out_d = clk_out_q;
    tc_d      = wrap;

    if (tick) begin
      cnt_d = wrap ? '0 : cnt_q + WIDTH'(1);
    end

    if (wrap && (mode == MODE_SQUARE)) begin
      clk_out_d = ~clk_out_q;
    end

    if (wrap) begin
      if (div_we) begin
        active_d = div;
      end else if (pend_q) begin
        active_d = pending_q;
      end
      pend_d = 1'b0;
    end else if (div_we) begin
      pending_d = div;
      pend_d    = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values computed in always_comb, independent of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      active_q  <= DEFAULT_DIV;
      pending_q <= '0;
      pend_q    <= 1'b0;
      tc_q      <= 1'b0;
      clk_out_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      pend_q    <= pend_d;
      tc_q      <= tc_d;
      clk_out_q <= clk_out_d;
    end
  end

  assign tc      = tc_q;
  assign clk_out = clk_out_q;
  assign pend    = pend_q;

endmodule

// File: rtl/prog_clock_divider.sv
// Multi-channel synchronous clock-enable divider. Each channel ticks on CP
// or on the previous channel's TC pulse, so long chains need no ripple clocks.
module prog_clock_divider
  import clkdiv_pkg::*;
#(
  parameter int               CH          = 4,
  parameter int               WIDTH       = 16,
  parameter logic [WIDTH-1:0] DEFAULT_DIV = WIDTH'(DEFAULT_DIV_C)
) (
  input  logic                CP,
  input  logic                RST,
  input  logic                EN,
  input  logic [CH*WIDTH-1:0] DIV,
  input  logic [CH-1:0]       DIV_WE,
  input  logic [CH-1:0]       CASC,
  input  logic [CH-1:0]       MODE,
  output logic [CH-1:0]       TC,
  output logic [CH-1:0]       CLK_OUT,
  output logic [CH-1:0]       PEND
);

  logic [CH-1:0] casc_eff;
  logic [CH-1:0] prev_tc;
  logic [CH-1:0] tick;

  // Channel 0 has no predecessor, so its cascade select is forced off.
  assign casc_eff = CASC & ~CH'(1);
  assign prev_tc  = CH'({TC, 1'b0});
  assign tick     = {CH{EN}} & (~casc_eff | prev_tc);

  for (genvar g = 0; g < CH; g++) begin : g_ch
    clkdiv_channel #(
      .WIDTH       (WIDTH),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk     (CP),
      .rst     (RST),
      .tick    (tick[g]),
      .div     (DIV[g*WIDTH +: WIDTH]),
      .div_we  (DIV_WE[g]),
      .mode    (MODE[g]),
      .tc      (TC[g]),
      .clk_out (CLK_OUT[g]),
      .pend    (PEND[g])
    );
  end

endmodule

// File: doc/prog_clock_divider.md
Name: prog_clock_divider

Overview:
- Multi-channel, runtime-programmable divider; replaces fixed-ratio ripple chains with fully synchronous clock-enable generation off the single system clock CP.
- Each channel divides a tick source by a programmable ratio N. The source is CP itself or the previous channel's terminal pulse, so chained ratios such as 50M→1M→10K→1 Hz are built without ripple clocks.
- Outputs are a one-cycle TC enable pulse and an optional square wave per channel; sits between the board oscillator and all timebase consumers (display scan, debounce, seconds count).

Parameters:
- CH, 4, number of divider channels.
- WIDTH, 16, width of each ratio/counter.
- DEFAULT_DIV, 16'd10, active ratio loaded into every channel at reset.

Ports:
- CP  in  1  system clock; all logic on rising edge.
- RST  in  1  synchronous reset, active-high.
- EN  in  1  global count enable; low freezes all counters.
- DIV  in  CH*WIDTH  ratio write data; slice i (bits i*WIDTH +: WIDTH) is for channel i.
- DIV_WE  in  CH  per-channel write strobe for DIV slice.
- CASC  in  CH  1: channel i ticks on TC[i-1]; 0: ticks every CP cycle. Bit 0 is ignored (ch0 always uses CP).
- MODE  in  CH  0: pulse only; 1: CLK_OUT toggles on each terminal count.
- TC  out  CH  registered one-cycle terminal-count pulse per channel.
- CLK_OUT  out  CH  registered square wave per channel; period 2N ticks, 50% duty.
- PEND  out  CH  1 while a written ratio awaits application.

Behaviour:
- Reset (RST=1 at an edge, any time including mid-count): cnt=0, active=DEFAULT_DIV, pending cleared, TC=0, CLK_OUT=0, PEND=0. RST has priority over all other inputs.
- tick_i = EN & (i>0 & CASC[i] ? TC[i-1] : 1).
- Effective ratio: Neff = (active==0) ? 1 : active. A ratio of 0 or 1 means divide-by-1.
- On tick_i with cnt==Neff-1: cnt<=0, TC[i]<=1 on the next cycle, and CLK_OUT[i] toggles if MODE[i]=1.
- On tick_i otherwise: cnt<=cnt+1, TC[i]<=0.
- No tick: cnt holds, TC[i]<=0, CLK_OUT holds.
- TC is high for exactly one CP cycle per wrap and is never high on consecutive cycles unless Neff=1 and ticks are consecutive.
- Latency, ch0 from CP: first TC is high in cycle N, counting cycle 0 as the first with RST=0 and EN=1, then every N cycles.
- Latency, cascaded channel: one extra CP cycle of skew per stage; the ratio product is exact.
- Ratio update: DIV_WE[i] captures the DIV slice into pending and sets PEND[i]. The pending value becomes active on the cycle of channel i's next wrap, and PEND clears then.
- DIV_WE on the same cycle as a wrap: the new slice becomes active immediately at that wrap, and PEND stays 0.
- A second write before application overwrites pending (last write wins).
- Because the active ratio never changes mid-count, no truncated or extended period is produced.
- MODE[i] 1→0: CLK_OUT[i] holds its current level (a frozen square output). 0→1: toggling resumes from the held level at the next wrap.
- EN low: all counters, CLK_OUT and PEND hold; TC=0; pending writes are still accepted.
- Counter arithmetic is WIDTH-bit unsigned; cnt never exceeds Neff-1, so it never overflows.

Decomposition:
- Package clkdiv_pkg: MODE_PULSE=1'b0, MODE_SQUARE=1'b1, and the default ratio constant.
- Sub-module clkdiv_channel contains one channel: counter, active/pending ratio registers, and TC, CLK_OUT and PEND registers, with ports tick, div, div_we and mode.
- Top level generates CH instances and wires the cascade mux (TC[i-1] into tick of i).

Test Plan:
- Basic divide: RST for 2 cycles, EN=1, ch0 DIV=50 written then wrapped in, CASC=0. → TC[0] is a 1-cycle pulse exactly every 50 cycles over 10 periods.
- Cascade: ch0=50, ch1=100 with CASC[1]=1. → TC[1] every 5000 CP cycles, 1 cycle after the coincident TC[0].
- Square mode: ch2 DIV=5, MODE[2]=1. → CLK_OUT[2] period 10 cycles, 5 high / 5 low; TC[2] every 5 cycles.
- Mid-count reprogram: ch0 active=10; at cnt=3 write 4. → PEND=1, the current period completes at 10, then the period is 4 and PEND=0.
- Same-cycle write and wrap: write 7 on the wrap cycle. → the next period is 7 and PEND never rises.
- Boundaries: DIV=0 and DIV=1 → TC high every cycle. EN low for 20 cycles mid-count → count resumes from its held value. RST mid-count → all outputs 0 next cycle and the ratio returns to DEFAULT_DIV=10.
